rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port among three writeback requesters: 0 = ALU, 1 = load/store unit, 2 = debug.
- Uses round-robin arbitration with a valid/ready handshake.
- Drives the register file write port from registered outputs.
- Keeps a 32-entry pending-write scoreboard so issue logic can stall on source registers whose writeback has not yet landed.

---
 rtl/rf_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter for the register file write port,
// with a pending-write scoreboard for issue-stage hazard lookup.
//
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_ready[2:0]  : 0=ALU 1=LSU 2=debug handshakes
//   req_addrN/req_dataN       : per-requester destination and data
//   rg_wrt_en/addr/data       : registered register file write port
//   sb_set_en/sb_set_addr     : issue marks a register pending
//   rs1/rs2_addr -> rs1/rs2_busy : combinational scoreboard lookup
//   sb_err                    : set hit an already-pending register
module rf_wb_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  output logic              rg_wrt_en,
  output logic [ADDR_W-1:0] rg_wrt_addr,
  output logic [DATA_W-1:0] rg_wrt_data,
  input  logic              sb_set_en,
  input  logic [ADDR_W-1:0] sb_set_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              sb_err
);

  logic [1:0]          rr_ptr;
  logic [1:0]          ptr_nxt;
  logic                hs;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                set_ok;
  logic                err_nxt;

  // Priority rotates with rr_ptr; grants are suppressed in reset.
  always_comb begin
    req_ready = 3'b000;
    if (reset) begin
      case (rr_ptr)
        2'd0: begin
          if (req_valid[0])      req_ready = 3'b001;
          else if (req_valid[1]) req_ready = 3'b010;
          else if (req_valid[2]) req_ready = 3'b100;
        end
        2'd1: begin
          if (req_valid[1])      req_ready = 3'b010;
          else if (req_valid[2]) req_ready = 3'b100;
          else if (req_valid[0]) req_ready = 3'b001;
        end
        2'd2: begin
          if (req_valid[2])      req_ready = 3'b100;
          else if (req_valid[0]) req_ready = 3'b001;
          else if (req_valid[1]) req_ready = 3'b010;
        end
        default: req_ready = 3'b000;
      endcase
    end
  end

  assign hs = |req_ready;

  always_comb begin
    win_addr = req_addr0;
    win_data = req_data0;
    ptr_nxt  = 2'd1;
    unique case (1'b1)
      req_ready[1]: begin
        win_addr = req_addr1;
        win_data = req_data1;
        ptr_nxt  = 2'd2;
      end
      req_ready[2]: begin
        win_addr = req_addr2;
        win_data = req_data2;
        ptr_nxt  = 2'd0;
      end
      default: ;
    endcase
  end

  // Clear lands on the commit edge; a same-edge set re-marks the bit.
  assign set_ok = sb_set_en && (sb_set_addr != '0);

  always_comb begin
    busy_nxt = busy;
    if (rg_wrt_en) busy_nxt[rg_wrt_addr] = 1'b0;
    if (set_ok)    busy_nxt[sb_set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign err_nxt = set_ok && busy[sb_set_addr] &&
                   !(rg_wrt_en && (rg_wrt_addr == sb_set_addr));

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr      <= 2'd0;
      rg_wrt_en   <= 1'b0;
      rg_wrt_addr <= '0;
      rg_wrt_data <= '0;
      busy        <= '0;
      sb_err      <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr      <= ptr_nxt;
        rg_wrt_addr <= win_addr;
        rg_wrt_data <= win_data;
      end
      // Writes to x0 complete the handshake but never reach the file.
      rg_wrt_en <= hs && (win_addr != '0);
      busy      <= busy_nxt;
      sb_err    <= err_nxt;
    end
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized bench for rf_wb_arbiter against a behavioural model
// of round-robin grants, writeback latency and the scoreboard.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [4:0]  req_addr0, req_addr1, req_addr2;
  logic [31:0] req_data0, req_data1, req_data2;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_addr;
  logic [31:0] rg_wrt_data;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        sb_err;

  rf_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_addr2(req_addr2),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_data2(req_data2),
    .rg_wrt_en(rg_wrt_en), .rg_wrt_addr(rg_wrt_addr),
    .rg_wrt_data(rg_wrt_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Requester intent and model state.
  bit        v [3];
  bit [4:0]  a [3];
  bit [31:0] d [3];
  int        ptr;
  bit        busy [32];
  bit        m_en;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  bit        m_err;
  bit        m_in_rst;

  task automatic model_reset();
    ptr = 0;
    m_en = 0; m_addr = 0; m_data = 0; m_err = 0;
    for (int i = 0; i < 32; i++) busy[i] = 0;
    for (int j = 0; j < 3; j++) v[j] = 0;
  endtask

  // mode 0: random traffic, mode 1: all three always valid
  task automatic cycle(input int mode, input bit rst_low);
    int g;
    bit [2:0] eg;
    bit set_ok, clr;
    @(negedge clk);
    reset = !rst_low;
    for (int j = 0; j < 3; j++) begin
      if (mode == 1) begin
        v[j] = 1;
        a[j] = 5'(5 + j);
        d[j] = 32'hA0 + 32'(j);
      end else if (!v[j] && ($urandom % 3 == 0)) begin
        v[j] = 1;
        a[j] = 5'($urandom % 16);
        d[j] = $urandom;
      end
    end
    req_valid = {v[2], v[1], v[0]};
    req_addr0 = a[0]; req_addr1 = a[1]; req_addr2 = a[2];
    req_data0 = d[0]; req_data1 = d[1]; req_data2 = d[2];
    sb_set_en   = (mode == 0) && ($urandom % 2 == 0);
    sb_set_addr = 5'($urandom % 16);
    rs1_addr    = 5'($urandom % 16);
    rs2_addr    = 5'($urandom % 16);
    #1;
    g = -1;
    if (!rst_low)
      for (int k = 0; k < 3; k++)
        if (g < 0 && v[(ptr + k) % 3]) g = (ptr + k) % 3;
    eg = (g < 0) ? 3'b000 : 3'(1 << g);
    chk("req_ready", 64'(req_ready), 64'(eg));
    chk("rg_wrt_en", 64'(rg_wrt_en), 64'(m_en));
    if (m_en || m_in_rst) begin
      chk("rg_wrt_addr", 64'(rg_wrt_addr), 64'(m_addr));
      chk("rg_wrt_data", 64'(rg_wrt_data), 64'(m_data));
    end
    chk("sb_err", 64'(sb_err), 64'(m_err));
    chk("rs1_busy", 64'(rs1_busy), 64'(busy[rs1_addr]));
    chk("rs2_busy", 64'(rs2_busy), 64'(busy[rs2_addr]));
    if (rst_low) begin
      model_reset();
      m_in_rst = 1;
    end else begin
      m_in_rst = 0;
      set_ok = sb_set_en && sb_set_addr != 0;
      clr = m_en;
      m_err = set_ok && busy[sb_set_addr] &&
              !(clr && m_addr == sb_set_addr);
      if (clr) busy[m_addr] = 0;
      if (set_ok) busy[sb_set_addr] = 1;
      if (g >= 0) begin
        ptr = (g + 1) % 3;
        m_en = (a[g] != 0);
        m_addr = a[g];
        m_data = d[g];
        v[g] = 0;
      end else begin
        m_en = 0;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '0;
    req_addr0 = '0; req_addr1 = '0; req_addr2 = '0;
    req_data0 = '0; req_data1 = '0; req_data2 = '0;
    sb_set_en = 1'b0; sb_set_addr = '0;
    rs1_addr = '0; rs2_addr = '0;
    model_reset();
    m_in_rst = 1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) cycle(0, 1);
    for (int i = 0; i < 12; i++) cycle(1, 0);
    for (int i = 0; i < 2; i++) cycle(0, 1);
    for (int i = 0; i < 4000; i++)
      cycle(0, ($urandom % 60) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
